ser_rx_frame: RTL and testbench



---
 rtl/ser_rx_frame.sv | 94 +++++++++
 tb/tb_ser_rx_frame.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ser_rx_frame.sv
// Serial frame receiver: samples din on enabled edges and rebuilds
// start / WIDTH data (LSB first) / stop frames into parallel words.
module ser_rx_frame #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = {din, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // A bad stop bit drops the word; dout keeps the last good one.
                    if (din) begin
                        dout_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ser_rx_frame.sv
// Self-checking bench for ser_rx_frame: frame table plus hand-written
// reset/idle sequences, with a pulse scoreboard checked at each negedge.
module tb_ser_rx_frame;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks;
    int errors;
    int busy_cnt;

    typedef struct {
        logic       is_err;
        logic [7:0] dout;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       alt;
        logic       exp_valid;
        logic [7:0] exp_dout;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[7];
    logic [7:0] last_good;

    ser_rx_frame #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .dout     (dout),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse scoreboard: every valid/frame_err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {30'd0, valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
                    check("pulse_dout", {24'd0, dout}, {24'd0, e.dout});
                end
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic alt);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop, data, 1'b0};
        if (stop) begin
            last_good = data;
            e.is_err  = 1'b0;
        end else begin
            e.is_err  = 1'b1;
        end
        e.dout = last_good;
        exp_q.push_back(e);
        for (int b = 0; b < 10; b++) begin
            if (alt) begin
                @(negedge clk);
                en  = 1'b0;
                din = bits[b];
            end
            @(negedge clk);
            en  = 1'b1;
            din = bits[b];
        end
    endtask

    initial begin
        logic [7:0] partial;

        checks    = 0;
        errors    = 0;
        busy_cnt  = 0;
        last_good = 8'h00;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, alt: 1'b0, exp_valid: 1'b1, exp_dout: 8'hA5};
        vecs[1] = '{data: 8'hA5, stop: 1'b1, alt: 1'b1, exp_valid: 1'b1, exp_dout: 8'hA5};
        vecs[2] = '{data: 8'h3C, stop: 1'b0, alt: 1'b0, exp_valid: 1'b0, exp_dout: 8'hA5};
        vecs[3] = '{data: 8'h01, stop: 1'b1, alt: 1'b0, exp_valid: 1'b1, exp_dout: 8'h01};
        vecs[4] = '{data: 8'h80, stop: 1'b1, alt: 1'b0, exp_valid: 1'b1, exp_dout: 8'h80};
        vecs[5] = '{data: 8'h00, stop: 1'b0, alt: 1'b0, exp_valid: 1'b0, exp_dout: 8'h80};
        vecs[6] = '{data: 8'hFF, stop: 1'b1, alt: 1'b0, exp_valid: 1'b1, exp_dout: 8'hFF};

        rst = 1'b1;
        en  = 1'b0;
        din = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_dout", {24'd0, dout}, 32'd0);
        check("reset_flags", {29'd0, valid, frame_err, busy}, 32'd0);
        rst = 1'b0;

        // Idle line: no frame may start, no pulses.
        en  = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_flags", {29'd0, valid, frame_err, busy}, 32'd0);
        end

        // Table frames are sent back-to-back with no idle bits between them.
        busy_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].alt);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, ~vecs[i].exp_valid});
            check($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            if (i == 0) check("busy_cycles", busy_cnt, 32'd9);
        end

        // Reset after start bit plus four data bits aborts the frame silently.
        partial = 8'hA5;
        @(negedge clk);
        en  = 1'b1;
        din = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            din = partial[b];
        end
        @(negedge clk);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        din = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        din       = 1'b1;
        last_good = 8'h00;
        check("abort_dout", {24'd0, dout}, 32'd0);
        check("abort_flags", {29'd0, valid, frame_err, busy}, 32'd0);

        send_frame(8'hFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_valid", {31'd0, valid}, 32'd1);
        check("post_reset_dout", {24'd0, dout}, 32'hFF);

        @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        check("pulse_one_cycle", {30'd0, valid, frame_err}, 32'd0);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
